// File: rtl/life_controller.sv
// life_controller: sequencing controller for the 8x8 Game-of-Life board.
// Holds the generation register, commits the next board from the external
// cell_array on a timer or on command, and row-scans the board onto LEDs.
module life_controller #(
  parameter int          GEN_PERIOD   = 12000000,
  parameter int          SCAN_PERIOD  = 1000,
  parameter int          GEN_W        = 16,
  parameter logic [63:0] INIT_PATTERN = 64'h001C_0000_0000_0000,
  parameter bit          AUTO_HALT    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [63:0]      cmd_data,
  output logic [63:0]      cells_out,
  input  logic [63:0]      cells_in,
  output logic [2:0]       row_sel,
  output logic [7:0]       leds_out,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_pulse,
  output logic             stable,
  output logic             extinct,
  output logic [1:0]       state
);

  localparam int TW = $clog2(GEN_PERIOD);
  localparam int SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [TW-1:0] GEN_LAST  = TW'(GEN_PERIOD - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_PAUSE = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    PAUSED   = 2'b00,
    RUNNING  = 2'b01,
    STEPPING = 2'b10,
    HALTED   = 2'b11
  } state_t;

  state_t          cur_state;
  state_t          next_state;
  logic [TW-1:0]   gen_timer;
  logic [SW-1:0]   scan_timer;
  logic            accept;
  logic            timer_expired;
  logic            do_load;
  logic            do_pause;
  logic            commit;
  logic            settled;

  assign state    = cur_state;
  assign leds_out = cells_out[{row_sel, 3'b000} +: 8];

  // State register; reset parks the controller in PAUSED.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= PAUSED;
    else     cur_state <= next_state;
  end

  // Next-state logic: commands from accepting states, timer commits and auto-halt.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      STEPPING: next_state = settled ? HALTED : PAUSED;
      RUNNING: begin
        if (do_load || do_pause)  next_state = PAUSED;
        else if (commit && settled) next_state = HALTED;
      end
      default: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN:   next_state = RUNNING;
            OP_STEP:  next_state = STEPPING;
            default:  next_state = PAUSED;
          endcase
        end
      end
    endcase
  end

  // Control outputs; a LOAD or PAUSE landing on the expiry cycle wins over the commit.
  always_comb begin
    cmd_ready     = rst || (cur_state != STEPPING);
    accept        = cmd_valid && cmd_ready && !rst;
    timer_expired = (cur_state == RUNNING) && (gen_timer == GEN_LAST);
    do_load       = accept && (cmd_op == OP_LOAD);
    do_pause      = accept && (cmd_op == OP_PAUSE);
    commit        = (cur_state == STEPPING) || (timer_expired && !do_load && !do_pause);
    settled       = AUTO_HALT && ((cells_in == cells_out) || (cells_in == 64'd0));
  end

  // Generation timer only runs while the controller stays in RUNNING.
  always_ff @(posedge clk) begin
    if (rst)
      gen_timer <= '0;
    else if (cur_state == RUNNING && next_state == RUNNING)
      gen_timer <= timer_expired ? '0 : gen_timer + TW'(1);
    else
      gen_timer <= '0;
  end

  // Board, generation counter and status flags: LOAD or commit update them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cells_out <= INIT_PATTERN;
      gen_count <= '0;
      gen_pulse <= 1'b0;
      stable    <= 1'b0;
      extinct   <= (INIT_PATTERN == 64'd0);
    end else if (do_load) begin
      cells_out <= cmd_data;
      gen_count <= '0;
      gen_pulse <= 1'b0;
      stable    <= 1'b0;
      extinct   <= (cmd_data == 64'd0);
    end else if (commit) begin
      cells_out <= cells_in;
      gen_count <= gen_count + GEN_W'(1);
      gen_pulse <= 1'b1;
      stable    <= (cells_in == cells_out);
      extinct   <= (cells_in == 64'd0);
    end else begin
      gen_pulse <= 1'b0;
    end
  end

  // Row scanner, free-running regardless of controller state.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_timer <= '0;
      row_sel    <= 3'd0;
    end else if (scan_timer == SCAN_LAST) begin
      scan_timer <= '0;
      row_sel    <= row_sel + 3'd1;
    end else begin
      scan_timer <= scan_timer + SW'(1);
    end
  end

endmodule

// File: tb/tb_life_controller.sv
// tb_life_controller: directed bench for life_controller with a behavioural
// Life next-state model closing the cells_out -> cells_in loop.
module tb_life_controller;

  localparam int GEN_W = 4;
  localparam logic [63:0] INIT  = 64'h001C_0000_0000_0000;
  localparam logic [63:0] VERT  = 64'h0808_0800_0000_0000;
  localparam logic [63:0] BLOCK = 64'h0000_0000_0000_0303;
  localparam logic [63:0] DOT   = 64'h0000_0000_0000_0001;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [63:0]      cmd_data;
  logic [63:0]      cells_out;
  logic [63:0]      cells_in;
  logic [2:0]       row_sel;
  logic [7:0]       leds_out;
  logic [GEN_W-1:0] gen_count;
  logic             gen_pulse;
  logic             stable;
  logic             extinct;
  logic [1:0]       state;

  int vectors = 0;
  int miscompares = 0;

  life_controller #(
    .GEN_PERIOD(4), .SCAN_PERIOD(2), .GEN_W(GEN_W),
    .INIT_PATTERN(INIT), .AUTO_HALT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cells_out(cells_out),
    .cells_in(cells_in), .row_sel(row_sel), .leds_out(leds_out),
    .gen_count(gen_count), .gen_pulse(gen_pulse), .stable(stable),
    .extinct(extinct), .state(state)
  );

  always #5 clk = ~clk;

  // Game-of-Life next state with dead cells beyond the board edge.
  function automatic logic [63:0] lifeNext(input logic [63:0] b);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(b[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = b[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  always_comb cells_in = lifeNext(cells_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Offer one command for a single edge; the DUT is ready in all callers.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [63:0] board;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;

    // 1. Reset values and row scan
    tick();
    checkOutput("rst_cells", cells_out, INIT);
    checkOutput("rst_state", 64'(state), 64'd0);
    checkOutput("rst_gen", 64'(gen_count), 64'd0);
    checkOutput("rst_extinct", 64'(extinct), 64'd0);
    checkOutput("rst_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_row", 64'(row_sel), 64'd0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput("scan_row", 64'(row_sel), 64'((i / 2) % 8));
      checkOutput("scan_leds", 64'(leds_out), ((i / 2) % 8 == 6) ? 64'h1C : 64'h0);
    end

    // 2. STEP
    applyStimulus(2'b10, '0);
    checkOutput("step_state", 64'(state), 64'd2);
    checkOutput("step_ready", 64'(cmd_ready), 64'd0);
    checkOutput("step_gen0", 64'(gen_count), 64'd0);
    tick();
    checkOutput("step_cells", cells_out, VERT);
    checkOutput("step_gen", 64'(gen_count), 64'd1);
    checkOutput("step_pulse", 64'(gen_pulse), 64'd1);
    checkOutput("step_state2", 64'(state), 64'd0);
    checkOutput("step_stable", 64'(stable), 64'd0);
    tick();
    checkOutput("step_pulse_off", 64'(gen_pulse), 64'd0);

    // 3. RUN: commits every 4 cycles, board alternates, counter wraps
    applyStimulus(2'b00, '0);
    checkOutput("run_state", 64'(state), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      tick(); tick(); tick();
      checkOutput("run_no_pulse", 64'(gen_pulse), 64'd0);
      checkOutput("run_gen_hold", 64'(gen_count), 64'((k) % 16));
      tick();
      board = (k % 2 == 1) ? INIT : VERT;
      checkOutput("run_cells", cells_out, board);
      checkOutput("run_gen", 64'(gen_count), 64'((1 + k) % 16));
      checkOutput("run_pulse", 64'(gen_pulse), 64'd1);
      checkOutput("run_stable", 64'(stable), 64'd0);
    end

    // 6a. PAUSE accepted on the expiry cycle suppresses the commit
    tick(); tick(); tick();
    applyStimulus(2'b01, '0);
    checkOutput("pause_state", 64'(state), 64'd0);
    checkOutput("pause_gen", 64'(gen_count), 64'd1);
    checkOutput("pause_cells", cells_out, VERT);
    checkOutput("pause_pulse", 64'(gen_pulse), 64'd0);

    // 4. LOAD a still-life block, then RUN -> HALTED
    applyStimulus(2'b11, BLOCK);
    checkOutput("load_cells", cells_out, BLOCK);
    checkOutput("load_gen", 64'(gen_count), 64'd0);
    checkOutput("load_state", 64'(state), 64'd0);
    checkOutput("load_pulse", 64'(gen_pulse), 64'd0);
    applyStimulus(2'b00, '0);
    tick(); tick(); tick(); tick();
    checkOutput("block_cells", cells_out, BLOCK);
    checkOutput("block_stable", 64'(stable), 64'd1);
    checkOutput("block_gen", 64'(gen_count), 64'd1);
    checkOutput("block_state", 64'(state), 64'd3);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("halt_no_pulse", 64'(gen_pulse), 64'd0);
    end
    checkOutput("halt_gen", 64'(gen_count), 64'd1);

    // 5. LOAD a lone cell, STEP -> extinct and HALTED; RUN commits once more
    applyStimulus(2'b11, DOT);
    checkOutput("dot_extinct0", 64'(extinct), 64'd0);
    applyStimulus(2'b10, '0);
    tick();
    checkOutput("dot_cells", cells_out, 64'd0);
    checkOutput("dot_extinct", 64'(extinct), 64'd1);
    checkOutput("dot_state", 64'(state), 64'd3);
    applyStimulus(2'b00, '0);
    checkOutput("dot_run", 64'(state), 64'd1);
    tick(); tick(); tick(); tick();
    checkOutput("dot_gen", 64'(gen_count), 64'd2);
    checkOutput("dot_state2", 64'(state), 64'd3);

    // 6b. Reset mid-RUN, with a LOAD offered in the same cycle
    applyStimulus(2'b00, '0);
    tick(); tick();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checkOutput("rst_run_ready", 64'(cmd_ready), 64'd1);
    tick();
    rst = 1'b0; cmd_valid = 1'b0;
    checkOutput("rst_run_cells", cells_out, INIT);
    checkOutput("rst_run_state", 64'(state), 64'd0);
    checkOutput("rst_run_gen", 64'(gen_count), 64'd0);
    checkOutput("rst_run_extinct", 64'(extinct), 64'd0);
    checkOutput("rst_run_stable", 64'(stable), 64'd0);
    checkOutput("rst_run_row", 64'(row_sel), 64'd0);
    tick(); tick(); tick(); tick(); tick();
    checkOutput("rst_run_idle_gen", 64'(gen_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
